// File: rtl/seq_gen_pkg.sv
// Shared types and line constants for the bit-serial frame transmitter.
package seq_gen_pkg;

    // Transmitter frame phases
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        DELIM = 2'd2,
        PAY   = 2'd3
    } state_t;

    // Line level of the single delimiter bit between preamble and payload
    localparam logic DELIM_BIT    = 1'b0;
    // Line level of every preamble bit
    localparam logic PREAMBLE_BIT = 1'b1;

endpackage

// File: rtl/seq_gen.sv
// Bit-serial frame transmitter: accepts a parallel payload over valid/ready,
// then sends PREAMBLE_LEN ones, one zero delimiter and the payload MSB first.
// All outputs are registered; next-state and next-output values are computed
// together so the outputs line up exactly with the state they describe.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int PREAMBLE_LEN = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_payload,
    output logic              o_ready,
    output logic              o_data,
    output logic              o_active,
    output logic              o_done
);

    localparam int MAX_LEN = (PREAMBLE_LEN > DATA_W) ? PREAMBLE_LEN : DATA_W;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DATA_W - 1);

    state_t              state;
    state_t              state_n;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_n;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   shreg_n;
    logic                accept;
    logic                last_n;
    logic                data_n;
    logic                active_n;
    logic                ready_n;

    // o_ready is registered, so accept never depends combinationally on itself
    assign accept = i_valid && o_ready;

    // Next state, counter and shift register; outputs derived from the next values
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = PRE;
                    cnt_n   = '0;
                    shreg_n = i_payload;
                end
            end
            PRE: begin
                if (cnt == PRE_LAST) begin
                    state_n = DELIM;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DELIM: begin
                state_n = PAY;
                cnt_n   = '0;
            end
            PAY: begin
                if (cnt == PAY_LAST) begin
                    cnt_n = '0;
                    if (accept) begin
                        // Back-to-back frame: next preamble follows with no gap
                        state_n = PRE;
                        shreg_n = i_payload;
                    end else begin
                        state_n = IDLE;
                        shreg_n = shreg << 1;
                    end
                end else begin
                    cnt_n   = cnt + CNT_W'(1);
                    shreg_n = shreg << 1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        last_n   = (state_n == PAY) && (cnt_n == PAY_LAST);
        active_n = (state_n != IDLE);
        ready_n  = (state_n == IDLE) || last_n;

        if (state_n == PRE) begin
            data_n = PREAMBLE_BIT;
        end else if (state_n == PAY) begin
            data_n = shreg_n[DATA_W-1];
        end else if (state_n == DELIM) begin
            data_n = DELIM_BIT;
        end else begin
            data_n = 1'b0;
        end
    end

    // State, counter, shift register and registered line outputs
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            o_data   <= 1'b0;
            o_active <= 1'b0;
            o_done   <= 1'b0;
            o_ready  <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shreg    <= shreg_n;
            o_data   <= data_n;
            o_active <= active_n;
            o_done   <= last_n;
            o_ready  <= ready_n;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Testbench for seq_gen: two instances (8-bit/4-preamble and 1-bit/1-preamble)
// checked every cycle against a queue model of the expected line bits.
module tb_seq_gen;

    logic       clk = 1'b0;
    logic       rstn;
    logic       a_valid;
    logic [7:0] a_payload;
    logic       a_ready, a_data, a_active, a_done;
    logic       b_valid;
    logic [0:0] b_payload;
    logic       b_ready, b_data, b_active, b_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_gen #(.DATA_W(8), .PREAMBLE_LEN(4)) dut_a (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_valid   (a_valid),
        .i_payload (a_payload),
        .o_ready   (a_ready),
        .o_data    (a_data),
        .o_active  (a_active),
        .o_done    (a_done)
    );

    seq_gen #(.DATA_W(1), .PREAMBLE_LEN(1)) dut_b (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_valid   (b_valid),
        .i_payload (b_payload),
        .o_ready   (b_ready),
        .o_data    (b_data),
        .o_active  (b_active),
        .o_done    (b_done)
    );

    // Model: queue of bits still to appear on the line; entry 0 is the bit on the line now
    typedef struct packed {
        logic d;
        logic last;
    } lbit_t;
    typedef lbit_t lq_t[$];

    lq_t qa;
    lq_t qb;

    function automatic lq_t build_frame(input int plen, input int dw, input logic [31:0] pay);
        lq_t f;
        for (int i = 0; i < plen; i++) f.push_back('{d: 1'b1, last: 1'b0});
        f.push_back('{d: 1'b0, last: 1'b0});
        for (int i = dw - 1; i >= 0; i--) f.push_back('{d: pay[i], last: (i == 0)});
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic ed, ea, eo, er;
        if (qa.size() > 0) begin
            ed = qa[0].d; ea = 1'b1; eo = qa[0].last; er = qa[0].last;
        end else begin
            ed = 1'b0; ea = 1'b0; eo = 1'b0; er = 1'b1;
        end
        chk("a_data",   {31'd0, a_data},   {31'd0, ed});
        chk("a_active", {31'd0, a_active}, {31'd0, ea});
        chk("a_done",   {31'd0, a_done},   {31'd0, eo});
        chk("a_ready",  {31'd0, a_ready},  {31'd0, er});
        if (qb.size() > 0) begin
            ed = qb[0].d; ea = 1'b1; eo = qb[0].last; er = qb[0].last;
        end else begin
            ed = 1'b0; ea = 1'b0; eo = 1'b0; er = 1'b1;
        end
        chk("b_data",   {31'd0, b_data},   {31'd0, ed});
        chk("b_active", {31'd0, b_active}, {31'd0, ea});
        chk("b_done",   {31'd0, b_done},   {31'd0, eo});
        chk("b_ready",  {31'd0, b_ready},  {31'd0, er});
    endtask

    // One clock: decide acceptance from the model, advance the model, check outputs
    task automatic step();
        bit   acc_a, acc_b;
        lq_t  f;
        acc_a = a_valid && ((qa.size() == 0) || qa[0].last);
        acc_b = b_valid && ((qb.size() == 0) || qb[0].last);
        @(posedge clk);
        if (qa.size() > 0) void'(qa.pop_front());
        if (qb.size() > 0) void'(qb.pop_front());
        if (acc_a) begin
            f = build_frame(4, 8, {24'd0, a_payload});
            foreach (f[i]) qa.push_back(f[i]);
        end
        if (acc_b) begin
            f = build_frame(1, 1, {31'd0, b_payload});
            foreach (f[i]) qb.push_back(f[i]);
        end
        #1;
        check_outputs();
    endtask

    initial begin
        logic [25:0] v;
        int          done_cnt;
        int          done_at0;
        int          done_at1;
        logic        act_all;

        rstn      = 1'b0;
        a_valid   = 1'b0;
        a_payload = 8'h00;
        b_valid   = 1'b0;
        b_payload = 1'b0;
        #12;
        check_outputs();
        rstn = 1'b1;
        step();
        step();

        // Single frame 0xA5
        a_valid = 1'b1; a_payload = 8'hA5;
        v = '0; done_cnt = 0; done_at0 = -1;
        for (int i = 0; i < 13; i++) begin
            step();
            if (i == 0) a_valid = 1'b0;
            v = {v[24:0], a_data};
            if (a_done) begin done_cnt++; done_at0 = i; end
            if (i == 12) chk("a5_ready_last", {31'd0, a_ready}, 32'd1);
        end
        chk("a5_bits", {19'd0, v[12:0]}, {19'd0, 13'b1111_0_10100101});
        chk("a5_done_cnt", done_cnt, 1);
        chk("a5_done_pos", done_at0, 12);
        step();
        step();

        // Back-to-back 0x3C then 0xC3 with valid held
        a_valid = 1'b1; a_payload = 8'h3C;
        v = '0; done_cnt = 0; done_at0 = -1; done_at1 = -1; act_all = 1'b1;
        for (int i = 0; i < 26; i++) begin
            step();
            if (i == 0) a_payload = 8'hC3;
            if (i == 13) a_valid = 1'b0;
            v = {v[24:0], a_data};
            act_all = act_all & a_active;
            if (a_done) begin
                if (done_cnt == 0) done_at0 = i; else done_at1 = i;
                done_cnt++;
            end
        end
        chk("b2b_bits", {6'd0, v}, {6'd0, 4'hF, 1'b0, 8'h3C, 4'hF, 1'b0, 8'hC3});
        chk("b2b_active", {31'd0, act_all}, 32'd1);
        chk("b2b_done_cnt", done_cnt, 2);
        chk("b2b_done_gap", done_at1 - done_at0, 13);
        step();

        // Busy hold: 0xFF offered from k+2 while 0x00 frame is on the line
        a_valid = 1'b1; a_payload = 8'h00;
        v = '0;
        for (int i = 0; i < 26; i++) begin
            step();
            if (i == 0) a_valid = 1'b0;
            if (i == 1) begin a_valid = 1'b1; a_payload = 8'hFF; end
            if (i == 13) a_valid = 1'b0;
            v = {v[24:0], a_data};
        end
        chk("hold_bits", {6'd0, v}, {6'd0, 4'hF, 1'b0, 8'h00, 4'hF, 1'b0, 8'hFF});
        step();

        // Asynchronous reset in the middle of the preamble
        a_valid = 1'b1; a_payload = 8'($urandom);
        step();
        a_valid = 1'b0;
        step();
        #2 rstn = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        chk("rst_data", {31'd0, a_data}, 32'd0);
        chk("rst_active", {31'd0, a_active}, 32'd0);
        chk("rst_ready", {31'd0, a_ready}, 32'd1);
        #1 rstn = 1'b1;
        step();
        a_valid = 1'b1; a_payload = 8'h5A;
        v = '0;
        for (int i = 0; i < 13; i++) begin
            step();
            if (i == 0) a_valid = 1'b0;
            v = {v[24:0], a_data};
        end
        chk("post_rst_bits", {19'd0, v[12:0]}, {19'd0, 13'b1111_0_01011010});
        step();

        // Minimal instance: 1-bit preamble, 1-bit payload of 1
        b_valid = 1'b1; b_payload = 1'b1;
        v = '0; done_at0 = -1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 0) b_valid = 1'b0;
            v = {v[24:0], b_data};
            if (b_done) done_at0 = i;
        end
        chk("small_bits", {29'd0, v[2:0]}, 32'b101);
        chk("small_done_pos", done_at0, 2);
        step();
        chk("small_idle", {31'd0, b_data}, 32'd0);

        // Randomized traffic on both instances, payload changing freely while busy
        for (int i = 0; i < 600; i++) begin
            a_valid   = ($urandom_range(0, 3) != 0);
            a_payload = 8'($urandom);
            b_valid   = ($urandom_range(0, 2) != 0);
            b_payload = 1'($urandom);
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
